// File: rtl/shamt_sel_shifter_pkg.sv
// Shared definitions for the shift-amount select shifter: mode encodings,
// FSM state type, default widths and the select-width helper.
package shamt_pkg;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_SHAMT_W = 5;
    localparam int unsigned DEF_NUM_SRC = 3;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A single source still needs a 1-bit select.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shamt_sel_shifter_if.sv
// Request/response bundle between the datapath control and the shifter.
interface shamt_sel_shifter_if
    import shamt_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned SHAMT_W = DEF_SHAMT_W,
    parameter int unsigned NUM_SRC = DEF_NUM_SRC
);
    localparam int unsigned SEL_W = sel_width(NUM_SRC);

    logic                       start;
    logic [SEL_W-1:0]           sel;
    logic [NUM_SRC*SHAMT_W-1:0] shamt_src;
    logic [1:0]                 mode;
    logic [DATA_W-1:0]          data_in;
    logic                       busy;
    logic                       done;
    logic [DATA_W-1:0]          data_out;
    logic                       sel_err;

    modport master (
        output start, sel, shamt_src, mode, data_in,
        input  busy, done, data_out, sel_err
    );

    modport slave (
        input  start, sel, shamt_src, mode, data_in,
        output busy, done, data_out, sel_err
    );

endinterface

// File: rtl/shamt_sel_shifter_src_mux.sv
// NUM_SRC:1 select of SHAMT_W-bit fields; an undecoded select yields 0 and
// raises the out-of-range flag.
module shamt_src_mux
    import shamt_pkg::*;
#(
    parameter int unsigned SHAMT_W = DEF_SHAMT_W,
    parameter int unsigned NUM_SRC = DEF_NUM_SRC,
    parameter int unsigned SEL_W   = sel_width(NUM_SRC)
) (
    input  logic [SEL_W-1:0]           sel,
    input  logic [NUM_SRC*SHAMT_W-1:0] src,
    output logic [SHAMT_W-1:0]         shamt_c,
    output logic                       oob_c
);

    always_comb begin
        shamt_c = '0;
        oob_c   = 1'b1;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (sel == SEL_W'(k)) begin
                shamt_c = src[k*SHAMT_W +: SHAMT_W];
                oob_c   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/shamt_sel_shifter.sv
// Iterative SLL/SRL/SRA shifter with selectable shift-amount source and a
// start/busy/done handshake. Define SHAMT_SEL_SHIFTER_STEP4_EN for 4-bit steps.
module shamt_sel_shifter
    import shamt_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned SHAMT_W = DEF_SHAMT_W,
    parameter int unsigned NUM_SRC = DEF_NUM_SRC
) (
    input  logic               clk,
    input  logic               reset_n,
    shamt_sel_shifter_if.slave bus
);

    localparam int unsigned SEL_W = sel_width(NUM_SRC);

    state_t              state, state_nx;
    logic [DATA_W-1:0]   work, work_nx;
    logic [SHAMT_W-1:0]  count, count_nx;
    logic [1:0]          mode_q, mode_nx;
    logic [SHAMT_W-1:0]  shamt_c;
    logic                oob_c;
    logic [SHAMT_W-1:0]  step_c;
    logic                accept_c;

    shamt_src_mux #(
        .SHAMT_W (SHAMT_W),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_src_mux (
        .sel     (bus.sel),
        .src     (bus.shamt_src),
        .shamt_c (shamt_c),
        .oob_c   (oob_c)
    );

    assign accept_c = (state == IDLE) && bus.start;

    // Per-cycle shift distance.
`ifdef SHAMT_SEL_SHIFTER_STEP4_EN
    assign step_c = (count >= SHAMT_W'(4)) ? SHAMT_W'(4) : SHAMT_W'(1);
`else
    assign step_c = SHAMT_W'(1);
`endif

    always_comb begin
        state_nx = state;
        work_nx  = work;
        count_nx = count;
        mode_nx  = mode_q;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    work_nx  = bus.data_in;
                    mode_nx  = bus.mode;
                    count_nx = shamt_c;
                    state_nx = (shamt_c != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                count_nx = count - step_c;
                case (mode_q)
                    MODE_SLL: work_nx = work << step_c;
                    MODE_SRL: work_nx = work >> step_c;
                    MODE_SRA: work_nx = DATA_W'($signed(work) >>> step_c);
                    default:  work_nx = work;
                endcase
                if (count == step_c) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, datapath and registered outputs; outputs track the next state so
    // busy/done line up with the SHIFT/DONE cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            work         <= '0;
            count        <= '0;
            mode_q       <= MODE_SLL;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.data_out <= '0;
            bus.sel_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            work     <= work_nx;
            count    <= count_nx;
            mode_q   <= mode_nx;
            bus.busy <= (state_nx == SHIFT);
            bus.done <= (state_nx == DONE);
            if (state_nx == DONE) bus.data_out <= work_nx;
            if (accept_c) bus.sel_err <= oob_c | (bus.mode == MODE_RSV);
        end
    end

endmodule

// File: tb/tb_shamt_sel_shifter.sv
// Scoreboard bench for shamt_sel_shifter: expected results queued at start,
// compared when done pulses.
module tb_shamt_sel_shifter;

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 5;
    localparam int unsigned NS = 3;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            lat;
        int            busy;
        int            c0;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   busy_cnt = 0;
    logic [DW-1:0] held = '0;
    exp_t sb[$];

    shamt_sel_shifter_if #(.DATA_W(DW), .SHAMT_W(SW), .NUM_SRC(NS)) bus ();

    shamt_sel_shifter #(.DATA_W(DW), .SHAMT_W(SW), .NUM_SRC(NS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    endtask

    function automatic int steps(input int sh);
`ifdef SHAMT_SEL_SHIFTER_STEP4_EN
        return sh / 4 + sh % 4;
`else
        return sh;
`endif
    endfunction

    function automatic logic [DW-1:0] model(input logic [1:0] m, input logic [DW-1:0] d, input int sh);
        logic signed [DW-1:0] sd;
        sd = d;
        case (m)
            2'b00:   return d << sh;
            2'b01:   return d >> sh;
            2'b10:   return DW'(sd >>> sh);
            default: return d;
        endcase
    endfunction

    // Output monitor: pops the scoreboard on done, checks data hold otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            busy_cnt = 0;
            held     = '0;
        end else if (bus.done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 64'(bus.done), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("data_out", 64'(bus.data_out), 64'(e.data));
                chk("sel_err", 64'(bus.sel_err), 64'(e.err));
                chk("latency", 64'(cyc - e.c0 + 1), 64'(e.lat));
                chk("busy_cycles", 64'(busy_cnt), 64'(e.busy));
                chk("busy_in_done", 64'(bus.busy), 64'd0);
            end
            busy_cnt = 0;
            held     = bus.data_out;
        end else begin
            if (bus.busy) busy_cnt++;
            chk("data_hold", 64'(bus.data_out), 64'(held));
        end
    end

    task automatic drive_start(input logic [1:0] sel, input logic [NS*SW-1:0] src,
                               input logic [1:0] mode, input logic [DW-1:0] d);
        @(negedge clk);
        bus.sel       = sel;
        bus.shamt_src = src;
        bus.mode      = mode;
        bus.data_in   = d;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.sel       = 2'($urandom_range(0, 3));
        bus.mode      = 2'($urandom_range(0, 3));
        bus.data_in   = $urandom;
        bus.shamt_src = NS*SW'($urandom);
    endtask

    task automatic do_txn(input logic [1:0] sel, input logic [NS*SW-1:0] src,
                          input logic [1:0] mode, input logic [DW-1:0] d,
                          input int pa, input int pb);
        exp_t e;
        int   sh;
        sh = (sel < 2'(NS)) ? int'(src[sel*SW +: SW]) : 0;
        drive_start(sel, src, mode, d);
        e.data = model(mode, d, sh);
        e.err  = (sel >= 2'(NS)) || (mode == 2'b11);
        e.busy = steps(sh);
        e.lat  = steps(sh) + 1;
        e.c0   = cyc;
        sb.push_back(e);
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) break;
            bus.start = (n == pa) || (n == pb);
        end
        bus.start = 1'b0;
        if (sb.size() != 0) begin
            chk("done_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.sel       = '0;
        bus.shamt_src = '0;
        bus.mode      = 2'b00;
        bus.data_in   = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_data_out", 64'(bus.data_out), 64'd0);
        chk("rst_sel_err", 64'(bus.sel_err), 64'd0);

        // Reset mid-shift: no entry queued, so any later done is spurious.
        drive_start(2'd0, {5'd0, 5'd0, 5'd20}, 2'b00, 32'h1);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        chk("midrst_data_out", 64'(bus.data_out), 64'd0);
        chk("midrst_sel_err", 64'(bus.sel_err), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("midrst_idle_busy", 64'(bus.busy), 64'd0);
        do_txn(2'd0, {5'd0, 5'd0, 5'd3}, 2'b00, 32'h1, 0, 0);

        // Directed cases from the plan.
        do_txn(2'd2, {5'd7, 5'd4, 5'd10}, 2'b01, 32'h8000_0000, 0, 0);
        do_txn(2'd1, {5'd7, 5'd4, 5'd10}, 2'b10, 32'hF000_0000, 0, 0);
        do_txn(2'd1, {5'd7, 5'd4, 5'd10}, 2'b01, 32'hF000_0000, 0, 0);
        do_txn(2'd3, {5'd7, 5'd4, 5'd10}, 2'b00, 32'hDEAD_BEEF, 0, 0);
        do_txn(2'd0, {5'd7, 5'd4, 5'd10}, 2'b00, 32'h0000_00FF, 0, 0);
        do_txn(2'd0, {5'd0, 5'd0, 5'd31}, 2'b00, 32'h1, 3, 10);
        do_txn(2'd0, {5'd0, 5'd0, 5'd5}, 2'b00, 32'h1, 0, 0);
        do_txn(2'd1, {5'd0, 5'd6, 5'd0}, 2'b11, 32'h1234_5678, 0, 0);
        do_txn(2'd2, {5'd31, 5'd0, 5'd0}, 2'b10, 32'h8000_0001, 0, 0);
        do_txn(2'd0, {5'd0, 5'd0, 5'd0}, 2'b01, 32'hCAFE_F00D, 0, 0);

        for (int i = 0; i < 25; i++) begin
            do_txn(2'($urandom_range(0, 3)), NS*SW'($urandom), 2'($urandom_range(0, 3)),
                   $urandom, 0, 0);
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/shamt_sel_shifter.md
Name: shamt_sel_shifter

Overview:
- Parametrised successor to the 3-way shift-amount select: picks a shift amount from NUM_SRC one-hot-decoded sources and drives an iterative, multi-cycle shifter.
- Sits beside the ALU in the multi-cycle MIPS datapath and serves SLL/SRL/SRA and their variable forms.
- Uses a start/busy/done handshake, so the control FSM stalls until the shift result is valid.

Parameters:
- DATA_W, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; must equal clog2(DATA_W).
- NUM_SRC, 3, number of shift-amount sources; range 2..8.
- SEL_W (localparam), max(1, clog2(NUM_SRC)), width of sel.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- sel  in  SEL_W  shift-amount source index.
- shamt_src  in  NUM_SRC*SHAMT_W  packed sources; source k is bits [k*SHAMT_W +: SHAMT_W].
- mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 reserved.
- data_in  in  DATA_W  operand.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; data_out is valid from this cycle.
- data_out  out  DATA_W  result; held until the next accepted start.
- sel_err  out  1  sticky flag: set when an accepted start had sel >= NUM_SRC or mode == 11. Cleared by the next accepted start that has a legal sel and mode.

Behaviour:
- Reset (async assert, sync deassert by the surrounding design): state IDLE; busy=0, done=0, data_out=0, sel_err=0, internal count=0. Reset during a shift aborts it; no done pulse is produced.
- Source select:
  - shamt = source[sel] when sel < NUM_SRC; otherwise shamt = 0.
  - This matches the legacy mux: an undecoded select gives 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1: latch data_in into the working register, latch mode, load count=shamt, update sel_err.
  - Next state is SHIFT if shamt != 0, else DONE.
  - start=0: stay in IDLE.
- SHIFT:
  - Each cycle, shift the working register by 1 and decrement count.
  - SLL fills with 0; SRL fills with 0; SRA replicates the MSB.
  - mode 11 behaves as no shift; the register is held while count still decrements.
  - When count reaches 1 and that final step is taken, go to DONE.
- DONE:
  - done=1 and busy=0 for one cycle; data_out = working register.
  - Next state is IDLE.
  - start in DONE is ignored; a new start is accepted the following cycle at the earliest.
- busy=1 in SHIFT only.
- start while busy is ignored, with no queueing and no error.
- Latency without the option: done asserts shamt+1 cycles after the start sample edge.
  - shamt=0 gives done after 1 cycle and data_out = data_in.
  - shamt=31 gives 32 cycles.
- Inputs other than start are don't-care after acceptance; all operand/select/mode values are latched.
- data_out changes only on entry to DONE or on reset.

Optional Feature:
- Macro SHAMT_SEL_SHIFTER_STEP4_EN.
- Defined: in SHIFT, step by 4 when count >= 4, else step by 1.
  - Latency is floor(shamt/4) + (shamt mod 4) + 1.
  - shamt=31 gives 7+3+1 = 11 cycles.
  - Fill rules are the same per mode.
- Undefined: 1-bit steps only; the 4-step logic is not synthesised.

Decomposition:
- Shared package shamt_pkg holds:
  - mode encodings MODE_SLL=2'b00, MODE_SRL=2'b01, MODE_SRA=2'b10, MODE_RSV=2'b11;
  - FSM state typedef (IDLE, SHIFT, DONE);
  - default widths.
- One natural sub-module: shamt_src_mux, a purely combinational NUM_SRC:1 select of SHAMT_W-bit fields plus an out-of-range flag. It is the generalised form of the legacy mux and can be reused by the decoder.

Test Plan:
- Reset mid-shift: start with SLL, sel=0, src0=20, data_in=0x1, then reset_n=0 at cycle 5 -> all outputs 0 immediately; no done after release; next start works normally.
- Source select: NUM_SRC=3, src={10,4,7}, sel=2, SRL, data_in=0x8000_0000 -> done at +8 cycles, data_out=0x0100_0000, sel_err=0.
- SRA fill: sel=1, src1=4, SRA, data_in=0xF000_0000 -> done at +5 cycles, data_out=0xFF00_0000. Same case with SRL -> 0x0F00_0000.
- Zero/illegal: sel=3 (>= NUM_SRC), data_in=0xDEAD_BEEF -> done at +1 cycle, data_out=0xDEAD_BEEF, sel_err=1. A following legal start clears sel_err.
- Busy protection: shamt=31 SLL, data_in=0x1, extra start pulses at +3 and +10 -> a single done at +32, data_out=0x8000_0000, busy high for 31 cycles.
- SHAMT_SEL_SHIFTER_STEP4_EN defined: shamt=31 SLL, data_in=0x1 -> done at +11, data_out=0x8000_0000. With shamt=5 -> done at +3, data_out=0x20.
